issue_scoreboard: RTL and testbench

ISSUE_SCOREBOARD -- requirements
Module: issue_scoreboard

---
 rtl/issue_scoreboard_if.sv | 34 +++
 rtl/issue_scoreboard.sv | 119 +++++++++++
 tb/tb_issue_scoreboard.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_scoreboard_if.sv
// Issue-side bundle for the scoreboard: decoded instruction in, ready back, registered issue copy out.
interface issue_scoreboard_if #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_FU   = 4
);
  localparam int unsigned REG_AW = $clog2(NUM_REGS);

  logic              iss_valid;
  logic              iss_ready;
  logic              iss_rs1_en;
  logic [REG_AW-1:0] iss_rs1_addr;
  logic              iss_rs2_en;
  logic [REG_AW-1:0] iss_rs2_addr;
  logic              iss_rd_en;
  logic [REG_AW-1:0] iss_rd_addr;
  logic [NUM_FU-1:0] iss_fu;

  logic              out_valid;
  logic [NUM_FU-1:0] out_fu;
  logic              out_rd_en;
  logic [REG_AW-1:0] out_rd_addr;

  modport master (
    output iss_valid, iss_rs1_en, iss_rs1_addr, iss_rs2_en, iss_rs2_addr,
    output iss_rd_en, iss_rd_addr, iss_fu,
    input  iss_ready, out_valid, out_fu, out_rd_en, out_rd_addr
  );

  modport slave (
    input  iss_valid, iss_rs1_en, iss_rs1_addr, iss_rs2_en, iss_rs2_addr,
    input  iss_rd_en, iss_rd_addr, iss_fu,
    output iss_ready, out_valid, out_fu, out_rd_en, out_rd_addr
  );
endinterface

// File: rtl/issue_scoreboard.sv
// In-order issue scoreboard: per-register pending bits, per-FU in-flight counters, RAW/WAW/structural
// hazard detection with same-cycle writeback bypass, and a one-cycle registered issue output.
module issue_scoreboard #(
  parameter int unsigned        NUM_REGS     = 32,
  parameter int unsigned        NUM_FU       = 4,
  parameter int unsigned        MAX_OUTST    = 4,
  parameter logic [NUM_FU-1:0]  FU_PIPELINED = 4'b0011,
  localparam int unsigned       REG_AW       = $clog2(NUM_REGS),
  localparam int unsigned       CW           = $clog2(MAX_OUTST + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  issue_scoreboard_if.slave        iss_if,
  input  logic                     flush_i,
  input  logic                     ext_stall_i,
  input  logic [NUM_FU-1:0]        wb_valid_i,
  input  logic [NUM_FU*REG_AW-1:0] wb_rd_addr_i,
  output logic [NUM_REGS-1:0]      pending_o,
  output logic [NUM_FU*CW-1:0]     fu_outst_o,
  output logic [2:0]               stall_cause_o,
  output logic                     sb_err_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CW-1:0]       outst_q [NUM_FU];
  logic [CW-1:0]       outst_d [NUM_FU];
  logic                err_q, err_d;
  logic                out_valid_q;
  logic [NUM_FU-1:0]   out_fu_q;
  logic                out_rd_en_q;
  logic [REG_AW-1:0]   out_rd_addr_q;

  logic [NUM_REGS-1:0] wb_clr;
  logic [NUM_FU-1:0]   fu_busy;
  logic [NUM_FU-1:0]   wb_underflow;
  logic                raw, waw, struct_haz, fu_onehot, ready, fire;

  // Registers being written back this cycle; used both to bypass hazards and to clear pending.
  always_comb begin
    wb_clr = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      if (wb_valid_i[f]) wb_clr[wb_rd_addr_i[f*REG_AW +: REG_AW]] = 1'b1;
    end
  end

  always_comb begin
    logic [CW:0] lim;
    fu_busy      = '0;
    wb_underflow = '0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      lim = FU_PIPELINED[f] ? (CW+1)'(MAX_OUTST) : (CW+1)'(1);
      // count - wb >= limit, rearranged to avoid underflow when count is 0
      fu_busy[f]      = {1'b0, outst_q[f]} >= lim + {{CW{1'b0}}, wb_valid_i[f]};
      wb_underflow[f] = wb_valid_i[f] && (outst_q[f] == '0);
    end
  end

  always_comb begin
    raw = (iss_if.iss_rs1_en && (iss_if.iss_rs1_addr != '0) &&
           pending_q[iss_if.iss_rs1_addr] && !wb_clr[iss_if.iss_rs1_addr]) ||
          (iss_if.iss_rs2_en && (iss_if.iss_rs2_addr != '0) &&
           pending_q[iss_if.iss_rs2_addr] && !wb_clr[iss_if.iss_rs2_addr]);
    waw = iss_if.iss_rd_en && (iss_if.iss_rd_addr != '0) &&
          pending_q[iss_if.iss_rd_addr] && !wb_clr[iss_if.iss_rd_addr];
    struct_haz    = |(fu_busy & iss_if.iss_fu);
    fu_onehot     = $onehot(iss_if.iss_fu);
    ready         = ~(raw | waw | struct_haz | ext_stall_i | flush_i | ~fu_onehot);
    fire          = iss_if.iss_valid & ready;
    stall_cause_o = {3{iss_if.iss_valid}} & {struct_haz, waw, raw};
  end

  always_comb begin
    pending_d = pending_q & ~wb_clr;
    if (fire && iss_if.iss_rd_en && (iss_if.iss_rd_addr != '0)) begin
      pending_d[iss_if.iss_rd_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
    for (int unsigned f = 0; f < NUM_FU; f++) begin
      outst_d[f] = outst_q[f] + CW'(fire & iss_if.iss_fu[f])
                              - CW'(wb_valid_i[f] & ~wb_underflow[f]);
    end
    err_d = err_q | (|wb_underflow) | (iss_if.iss_valid & ~fu_onehot);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q     <= '0;
      err_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_fu_q      <= '0;
      out_rd_en_q   <= 1'b0;
      out_rd_addr_q <= '0;
      for (int unsigned f = 0; f < NUM_FU; f++) outst_q[f] <= '0;
    end else begin
      pending_q   <= pending_d;
      err_q       <= err_d;
      out_valid_q <= fire;
      for (int unsigned f = 0; f < NUM_FU; f++) outst_q[f] <= outst_d[f];
      if (fire) begin
        out_fu_q      <= iss_if.iss_fu;
        out_rd_en_q   <= iss_if.iss_rd_en;
        out_rd_addr_q <= iss_if.iss_rd_addr;
      end
    end
  end

  always_comb begin
    for (int unsigned f = 0; f < NUM_FU; f++) fu_outst_o[f*CW +: CW] = outst_q[f];
  end

  assign pending_o          = pending_q;
  assign sb_err_o           = err_q;
  assign iss_if.iss_ready   = ready;
  assign iss_if.out_valid   = out_valid_q;
  assign iss_if.out_fu      = out_fu_q;
  assign iss_if.out_rd_en   = out_rd_en_q;
  assign iss_if.out_rd_addr = out_rd_addr_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Bench for issue_scoreboard: cycle-by-cycle model comparison plus directed scenarios with literal
// expectations.
module tb_issue_scoreboard;

  localparam logic [3:0] PIPE = 4'b0011;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush, ext_stall;
  logic [3:0]  wb_valid;
  logic [19:0] wb_rd_addr;
  logic [31:0] pending;
  logic [11:0] fu_outst;
  logic [2:0]  stall_cause;
  logic        sb_err;

  int n_checks = 0;
  int n_fail   = 0;

  issue_scoreboard_if #(.NUM_REGS(32), .NUM_FU(4)) bus ();

  issue_scoreboard dut (
    .clk           (clk),
    .rst           (rst),
    .iss_if        (bus),
    .flush_i       (flush),
    .ext_stall_i   (ext_stall),
    .wb_valid_i    (wb_valid),
    .wb_rd_addr_i  (wb_rd_addr),
    .pending_o     (pending),
    .fu_outst_o    (fu_outst),
    .stall_cause_o (stall_cause),
    .sb_err_o      (sb_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pend = '0;
  int          m_cnt [4] = '{0, 0, 0, 0};
  bit          m_err = 0, m_ov = 0, m_orde = 0;
  logic [3:0]  m_ofu = '0;
  logic [4:0]  m_ord = '0;
  logic [31:0] n_pend;
  int          n_cnt [4];
  bit          n_err, n_ov, n_orde;
  logic [3:0]  n_ofu;
  logic [4:0]  n_ord;

  function automatic logic [4:0] wb_addr(int f);
    return wb_rd_addr[f*5 +: 5];
  endfunction

  function automatic bit written_back(logic [4:0] a);
    for (int f = 0; f < 4; f++) if (wb_valid[f] && wb_addr(f) == a) return 1;
    return 0;
  endfunction

  function automatic bit blocked(bit en, logic [4:0] a);
    return en && a != 0 && m_pend[a] && !written_back(a);
  endfunction

  bit         e_raw, e_waw, e_st, e_oh, e_rdy, e_fire;
  logic [2:0] e_sc;
  logic [31:0] t_pend;
  int          t_cnt [4];

  always @(negedge clk) begin : compare
    e_raw = blocked(bus.iss_rs1_en, bus.iss_rs1_addr) || blocked(bus.iss_rs2_en, bus.iss_rs2_addr);
    e_waw = blocked(bus.iss_rd_en, bus.iss_rd_addr);
    e_st  = 0;
    for (int f = 0; f < 4; f++)
      if (bus.iss_fu[f] && (m_cnt[f] - int'(wb_valid[f]) >= (PIPE[f] ? 4 : 1))) e_st = 1;
    e_oh   = $countones(bus.iss_fu) == 1;
    e_rdy  = !(e_raw || e_waw || e_st || ext_stall || flush || !e_oh);
    e_fire = bus.iss_valid && e_rdy;
    e_sc   = bus.iss_valid ? {e_st, e_waw, e_raw} : 3'b000;

    check("iss_ready", 64'(bus.iss_ready), 64'(e_rdy));
    check("stall_cause", 64'(stall_cause), 64'(e_sc));
    check("pending", 64'(pending), 64'(m_pend));
    for (int f = 0; f < 4; f++) check("fu_outst", 64'(fu_outst[f*3 +: 3]), 64'(m_cnt[f]));
    check("sb_err", 64'(sb_err), 64'(m_err));
    check("out_valid", 64'(bus.out_valid), 64'(m_ov));
    check("out_fu", 64'(bus.out_fu), 64'(m_ofu));
    check("out_rd_en", 64'(bus.out_rd_en), 64'(m_orde));
    check("out_rd_addr", 64'(bus.out_rd_addr), 64'(m_ord));

    t_pend = m_pend;
    for (int f = 0; f < 4; f++) begin
      if (wb_valid[f]) t_pend[wb_addr(f)] = 1'b0;
      t_cnt[f] = m_cnt[f] + ((e_fire && bus.iss_fu[f]) ? 1 : 0)
                          - ((wb_valid[f] && m_cnt[f] > 0) ? 1 : 0);
    end
    if (e_fire && bus.iss_rd_en && bus.iss_rd_addr != 0) t_pend[bus.iss_rd_addr] = 1'b1;
    t_pend[0] = 1'b0;
    n_pend <= t_pend;
    n_cnt  <= t_cnt;
    n_err  <= m_err || (bus.iss_valid && !e_oh) ||
              (wb_valid[0] && m_cnt[0] == 0) || (wb_valid[1] && m_cnt[1] == 0) ||
              (wb_valid[2] && m_cnt[2] == 0) || (wb_valid[3] && m_cnt[3] == 0);
    n_ov   <= e_fire;
    n_ofu  <= e_fire ? bus.iss_fu : m_ofu;
    n_orde <= e_fire ? bus.iss_rd_en : m_orde;
    n_ord  <= e_fire ? bus.iss_rd_addr : m_ord;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend <= '0; m_cnt <= '{0, 0, 0, 0}; m_err <= 0;
      m_ov <= 0; m_ofu <= '0; m_orde <= 0; m_ord <= '0;
    end else begin
      m_pend <= n_pend; m_cnt <= n_cnt; m_err <= n_err;
      m_ov <= n_ov; m_ofu <= n_ofu; m_orde <= n_orde; m_ord <= n_ord;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clr();
    bus.iss_valid = 0; bus.iss_rs1_en = 0; bus.iss_rs1_addr = '0; bus.iss_rs2_en = 0;
    bus.iss_rs2_addr = '0; bus.iss_rd_en = 0; bus.iss_rd_addr = '0; bus.iss_fu = '0;
    flush = 0; ext_stall = 0; wb_valid = '0; wb_rd_addr = '0;
  endtask

  task automatic drive(input bit r1e, input logic [4:0] r1, input bit rde, input logic [4:0] rd,
                       input logic [3:0] fu);
    bus.iss_valid = 1; bus.iss_rs1_en = r1e; bus.iss_rs1_addr = r1;
    bus.iss_rd_en = rde; bus.iss_rd_addr = rd; bus.iss_fu = fu;
  endtask

  task automatic wb(input int f, input logic [4:0] a);
    wb_valid[f] = 1'b1;
    wb_rd_addr[f*5 +: 5] = a;
  endtask

  initial begin
    clr();
    tick(); tick();
    settle();
    check("rst_pending", 64'(pending), 64'h0);
    check("rst_outst", 64'(fu_outst), 64'h0);
    check("rst_out_valid", 64'(bus.out_valid), 64'h0);
    rst = 0;

    // RAW on x5 with same-cycle writeback bypass
    drive(0, 0, 1, 5'd5, 4'b0001); settle();
    check("raw_first_ready", 64'(bus.iss_ready), 64'h1);
    tick(); clr(); settle();
    check("raw_pend5_set", 64'(pending[5]), 64'h1);
    check("raw_out_rd", 64'(bus.out_rd_addr), 64'h5);
    drive(1, 5'd5, 1, 5'd6, 4'b0010); settle();
    check("raw_stall_ready", 64'(bus.iss_ready), 64'h0);
    check("raw_stall_cause", 64'(stall_cause), 64'h1);
    tick(); settle();
    check("raw_no_fire", 64'(bus.out_valid), 64'h0);
    wb(0, 5'd5); settle();
    check("raw_bypass_ready", 64'(bus.iss_ready), 64'h1);
    tick(); clr(); settle();
    check("raw_pend5_clr", 64'(pending[5]), 64'h0);
    check("raw_pend6", 64'(pending[6]), 64'h1);
    check("raw_out_fu", 64'(bus.out_fu), 64'h2);
    wb(1, 5'd6); tick(); clr();

    // Blocking FU2
    drive(0, 0, 1, 5'd8, 4'b0100); tick(); clr();
    drive(0, 0, 1, 5'd9, 4'b0100); settle();
    check("blk_stall", 64'(stall_cause), 64'h4);
    tick(); settle();
    check("blk_still", 64'(bus.iss_ready), 64'h0);
    wb(2, 5'd8); settle();
    check("blk_wb_ready", 64'(bus.iss_ready), 64'h1);
    tick(); clr(); settle();
    check("blk_outst2", 64'(fu_outst[8:6]), 64'h1);
    check("blk_pend", 64'(pending[9:8]), 64'h2);
    wb(2, 5'd9); tick(); clr();

    // Pipelined FU0 fills to four
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 5'(10 + i), 4'b0001); tick();
    end
    clr(); settle();
    check("pipe_full", 64'(fu_outst[2:0]), 64'h4);
    drive(0, 0, 1, 5'd14, 4'b0001); settle();
    check("pipe_fifth_stall", 64'(stall_cause), 64'h4);
    wb(0, 5'd10); settle();
    check("pipe_fifth_ready", 64'(bus.iss_ready), 64'h1);
    tick(); clr(); settle();
    check("pipe_still4", 64'(fu_outst[2:0]), 64'h4);
    for (int i = 0; i < 4; i++) begin
      wb(0, 5'(11 + i)); tick(); clr();
    end
    settle();
    check("pipe_drained", 64'(fu_outst[2:0]), 64'h0);

    // Set beats clear on x7; x0 never pends
    drive(0, 0, 1, 5'd7, 4'b0010); tick(); clr();
    drive(0, 0, 1, 5'd7, 4'b0010); wb(1, 5'd7); settle();
    check("setclr_ready", 64'(bus.iss_ready), 64'h1);
    tick(); clr(); settle();
    check("setclr_pend7", 64'(pending[7]), 64'h1);
    check("setclr_outst1", 64'(fu_outst[5:3]), 64'h1);
    wb(1, 5'd7); tick(); clr();
    drive(1, 5'd0, 1, 5'd0, 4'b0010); tick(); clr(); settle();
    check("x0_pending", 64'(pending), 64'h0);
    wb(1, 5'd0); tick(); clr();

    // Flush and writeback underflow
    drive(0, 0, 1, 5'd20, 4'b0001); tick(); clr();
    drive(1, 5'd20, 1, 5'd21, 4'b0001); flush = 1; settle();
    check("flush_ready", 64'(bus.iss_ready), 64'h0);
    tick(); clr(); settle();
    check("flush_out_valid", 64'(bus.out_valid), 64'h0);
    check("flush_pending", 64'(pending), 64'h0010_0000);
    wb(1, 5'd3); tick(); clr(); settle();
    check("uflow_err", 64'(sb_err), 64'h1);
    check("uflow_outst1", 64'(fu_outst[5:3]), 64'h0);
    tick(); settle();
    check("uflow_err_held", 64'(sb_err), 64'h1);
    wb(0, 5'd20); tick(); clr();
    drive(0, 0, 1, 5'd22, 4'b0011); settle();
    check("nonhot_ready", 64'(bus.iss_ready), 64'h0);
    tick(); clr();

    // Asynchronous reset mid-operation
    drive(0, 0, 1, 5'd5, 4'b0001); tick();
    drive(0, 0, 1, 5'd7, 4'b0001); tick(); clr(); settle();
    check("prerst_pending", 64'(pending), 64'hA0);
    check("prerst_outst0", 64'(fu_outst[2:0]), 64'h2);
    rst = 1; #1;
    check("async_pending", 64'(pending), 64'h0);
    check("async_outst", 64'(fu_outst), 64'h0);
    check("async_err", 64'(sb_err), 64'h0);
    tick(); rst = 0;
    wb(0, 5'd5); tick(); clr(); settle();
    check("postrst_err", 64'(sb_err), 64'h1);
    check("postrst_outst0", 64'(fu_outst[2:0]), 64'h0);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
